// File: rtl/tpu_pkg.sv
// Shared types and helpers for the streaming 2D convolution engine.
//   data_t       : default-width signed data word
//   acc_t        : default-width signed accumulator
//   conv_state_e : control FSM states
//   sat_shift    : arithmetic right shift followed by saturation to a signed width
package tpu_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ACC_W_DEF  = 40;

    typedef logic signed [DATA_W_DEF-1:0] data_t;
    typedef logic signed [ACC_W_DEF-1:0]  acc_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoadK,
        StLoadM,
        StCompute,
        StOutput
    } conv_state_e;

    // Works on a 64-bit container so any accumulator/data width up to 64 can share it.
    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                     input int unsigned shift,
                                                     input int unsigned data_w);
        logic signed [63:0] v;
        logic signed [63:0] v_max;
        logic signed [63:0] v_min;
        v     = acc >>> shift;
        v_max = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        v_min = -(64'sd1 <<< (data_w - 1));
        if (v > v_max) begin
            return v_max;
        end
        if (v < v_min) begin
            return v_min;
        end
        return v;
    endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Signed multiply-accumulate for one convolution output.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_en         : accumulate this cycle
//   i_clr        : start a new sum (accumulator replaced by this term)
//   i_zero       : padding tap, contributes zero
//   i_a, i_b     : kernel and matrix operands
//   o_result     : accumulator shifted and saturated to DATA_W
module conv_mac_unit
    import tpu_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ACC_W     = ACC_W_DEF,
    parameter int unsigned OUT_SHIFT = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic                     i_clr,
    input  logic                     i_zero,
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    output logic signed [DATA_W-1:0] o_result
);

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_term;
    logic signed [ACC_W-1:0]    r_acc;

    assign w_prod   = (2*DATA_W)'(i_a) * (2*DATA_W)'(i_b);
    assign w_term   = i_zero ? '0 : ACC_W'(w_prod);
    assign o_result = DATA_W'(sat_shift(64'(r_acc), OUT_SHIFT, DATA_W));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= (i_clr ? '0 : r_acc) + w_term;
        end
    end

endmodule

// File: rtl/conv2d_stream_engine.sv
// Zero-padded "same" 2D convolution, one MAC per cycle, results streamed in raster order.
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_insert_kernel   : capture i_data_in as next kernel word
//   i_insert_matrix   : capture i_data_in as next matrix word
//   i_data_in         : serial kernel/matrix word, raster order
//   i_ready           : consumer accepts o_data_out this cycle
//   o_done            : o_data_out valid
//   o_data_out        : result word, raster order
//   o_busy            : computing or presenting results; inserts ignored
//   o_kernel_loaded   : a complete kernel is held
module conv2d_stream_engine
    import tpu_pkg::*;
#(
    parameter int unsigned MATRIX_DIM = 16,
    parameter int unsigned KERNEL_DIM = 3,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned ACC_W      = ACC_W_DEF,
    parameter int unsigned OUT_SHIFT  = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_insert_kernel,
    input  logic                     i_insert_matrix,
    input  logic signed [DATA_W-1:0] i_data_in,
    input  logic                     i_ready,
    output logic                     o_done,
    output logic signed [DATA_W-1:0] o_data_out,
    output logic                     o_busy,
    output logic                     o_kernel_loaded
);

    localparam int unsigned KK     = KERNEL_DIM * KERNEL_DIM;
    localparam int unsigned DD     = MATRIX_DIM * MATRIX_DIM;
    localparam int unsigned PAD    = (KERNEL_DIM - 1) / 2;
    localparam int unsigned LIDX_W = $clog2(DD);
    localparam int unsigned KIDX_W = (KK > 1) ? $clog2(KK) : 1;
    localparam int unsigned POS_W  = $clog2(MATRIX_DIM);
    localparam int unsigned KPOS_W = (KERNEL_DIM > 1) ? $clog2(KERNEL_DIM) : 1;

    conv_state_e              r_state;
    logic [LIDX_W-1:0]        r_load_idx;
    logic                     r_kernel_loaded;
    logic                     r_matrix_full;   // complete matrix waiting for a kernel
    logic                     r_fin;           // all taps summed, finalise this cycle
    logic                     r_done;
    logic                     r_busy;
    logic [POS_W-1:0]         r_row;
    logic [POS_W-1:0]         r_col;
    logic [KPOS_W-1:0]        r_ki;
    logic [KPOS_W-1:0]        r_kj;
    logic signed [DATA_W-1:0] r_data_out;
    logic signed [DATA_W-1:0] r_kernel [2**KIDX_W];
    logic signed [DATA_W-1:0] r_matrix [2**LIDX_W];

    logic                     w_k_we;
    logic                     w_m_we;
    logic                     w_k_last;
    logic                     w_m_last;
    logic [LIDX_W-1:0]        w_wr_idx;
    int                       w_mr;
    int                       w_mc;
    logic                     w_pad;
    logic [LIDX_W-1:0]        w_m_addr;
    logic [KIDX_W-1:0]        w_k_addr;
    logic                     w_last_tap;
    logic                     w_last_pos;
    logic                     w_mac_en;
    logic                     w_mac_clr;
    logic signed [DATA_W-1:0] w_mac_result;

    always_comb begin
        // The first word of a load is captured from IDLE at index 0.
        w_wr_idx   = (r_state == StIdle) ? '0 : r_load_idx;
        w_k_we     = i_insert_kernel &&
                     ((r_state == StIdle) || (r_state == StLoadK && !r_kernel_loaded));
        w_m_we     = i_insert_matrix &&
                     ((r_state == StIdle && !i_insert_kernel) ||
                      (r_state == StLoadM && !r_matrix_full));
        w_k_last   = (w_wr_idx == LIDX_W'(KK - 1));
        w_m_last   = (w_wr_idx == LIDX_W'(DD - 1));
        w_mr       = int'(r_row) + int'(r_ki) - int'(PAD);
        w_mc       = int'(r_col) + int'(r_kj) - int'(PAD);
        w_pad      = (w_mr < 0) || (w_mr >= int'(MATRIX_DIM)) ||
                     (w_mc < 0) || (w_mc >= int'(MATRIX_DIM));
        w_m_addr   = w_pad ? '0 : LIDX_W'(w_mr * int'(MATRIX_DIM) + w_mc);
        w_k_addr   = KIDX_W'(int'(r_ki) * int'(KERNEL_DIM) + int'(r_kj));
        w_last_tap = (r_ki == KPOS_W'(KERNEL_DIM - 1)) && (r_kj == KPOS_W'(KERNEL_DIM - 1));
        w_last_pos = (r_row == POS_W'(MATRIX_DIM - 1)) && (r_col == POS_W'(MATRIX_DIM - 1));
        w_mac_en   = (r_state == StCompute) && !r_fin;
        w_mac_clr  = (r_ki == '0) && (r_kj == '0);
    end

    // Storage carries no reset; its contents are only meaningful after a completed load.
    always_ff @(posedge i_clk) begin
        if (w_k_we) begin
            r_kernel[KIDX_W'(w_wr_idx)] <= i_data_in;
        end
        if (w_m_we) begin
            r_matrix[w_wr_idx] <= i_data_in;
        end
    end

    conv_mac_unit #(
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_mac (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (w_mac_en),
        .i_clr    (w_mac_clr),
        .i_zero   (w_pad),
        .i_a      (r_kernel[w_k_addr]),
        .i_b      (r_matrix[w_m_addr]),
        .o_result (w_mac_result)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= StIdle;
            r_load_idx      <= '0;
            r_kernel_loaded <= 1'b0;
            r_matrix_full   <= 1'b0;
            r_fin           <= 1'b0;
            r_done          <= 1'b0;
            r_busy          <= 1'b0;
            r_row           <= '0;
            r_col           <= '0;
            r_ki            <= '0;
            r_kj            <= '0;
            r_data_out      <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_insert_kernel) begin
                        r_state         <= StLoadK;
                        r_kernel_loaded <= 1'b0;
                    end else if (i_insert_matrix) begin
                        r_state       <= StLoadM;
                        r_matrix_full <= 1'b0;
                    end
                end
                StLoadK: begin
                    if (!i_insert_kernel) begin
                        r_state    <= StIdle;
                        r_load_idx <= '0;
                    end
                end
                StLoadM: begin
                    if (!i_insert_matrix) begin
                        r_state    <= StIdle;
                        r_load_idx <= '0;
                    end
                end
                StCompute: begin
                    if (!r_fin) begin
                        if (w_last_tap) begin
                            r_ki  <= '0;
                            r_kj  <= '0;
                            r_fin <= 1'b1;
                        end else if (r_kj == KPOS_W'(KERNEL_DIM - 1)) begin
                            r_kj <= '0;
                            r_ki <= r_ki + KPOS_W'(1);
                        end else begin
                            r_kj <= r_kj + KPOS_W'(1);
                        end
                    end else begin
                        r_fin      <= 1'b0;
                        r_data_out <= w_mac_result;
                        r_done     <= 1'b1;
                        r_state    <= StOutput;
                    end
                end
                StOutput: begin
                    if (i_ready) begin
                        r_done <= 1'b0;
                        if (w_last_pos) begin
                            r_row   <= '0;
                            r_col   <= '0;
                            r_busy  <= 1'b0;
                            r_state <= StIdle;
                        end else begin
                            if (r_col == POS_W'(MATRIX_DIM - 1)) begin
                                r_col <= '0;
                                r_row <= r_row + POS_W'(1);
                            end else begin
                                r_col <= r_col + POS_W'(1);
                            end
                            r_state <= StCompute;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase

            // Load bookkeeping overrides the state transitions above when a load completes.
            if (w_k_we) begin
                if (w_k_last) begin
                    r_kernel_loaded <= 1'b1;
                    r_load_idx      <= '0;
                    if (r_matrix_full) begin
                        r_state       <= StCompute;
                        r_busy        <= 1'b1;
                        r_matrix_full <= 1'b0;
                    end
                end else begin
                    r_load_idx <= w_wr_idx + LIDX_W'(1);
                end
            end
            if (w_m_we) begin
                if (w_m_last) begin
                    r_load_idx <= '0;
                    if (r_kernel_loaded) begin
                        r_state <= StCompute;
                        r_busy  <= 1'b1;
                    end else begin
                        r_matrix_full <= 1'b1;
                    end
                end else begin
                    r_load_idx <= w_wr_idx + LIDX_W'(1);
                end
            end
        end
    end

    assign o_done          = r_done;
    assign o_data_out      = r_data_out;
    assign o_busy          = r_busy;
    assign o_kernel_loaded = r_kernel_loaded;

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Scoreboard bench for conv2d_stream_engine: two instances share all inputs, one with
// OUT_SHIFT=0 and one with OUT_SHIFT=2; each has its own expected-result queue.
module tb_conv2d_stream_engine;
    import tpu_pkg::*;

    localparam int D = 16;
    localparam int K = 3;
    localparam int P = 1;

    logic          clk;
    logic          rst;
    logic          ins_k;
    logic          ins_m;
    logic          ready;
    data_t         din;
    logic          done0;
    logic          busy0;
    logic          kl0;
    data_t         dout0;
    logic          done2;
    logic          busy2;
    logic          kl2;
    data_t         dout2;

    int            checks = 0;
    int            errors = 0;
    int            n_hs   = 0;
    int            km [K*K];
    int            mm [D*D];
    longint        q0 [$];
    longint        q2 [$];

    conv2d_stream_engine #(
        .MATRIX_DIM (D),
        .KERNEL_DIM (K),
        .DATA_W     (16),
        .ACC_W      (40),
        .OUT_SHIFT  (0)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_insert_kernel (ins_k),
        .i_insert_matrix (ins_m),
        .i_data_in       (din),
        .i_ready         (ready),
        .o_done          (done0),
        .o_data_out      (dout0),
        .o_busy          (busy0),
        .o_kernel_loaded (kl0)
    );

    conv2d_stream_engine #(
        .MATRIX_DIM (D),
        .KERNEL_DIM (K),
        .DATA_W     (16),
        .ACC_W      (40),
        .OUT_SHIFT  (2)
    ) dut_s2 (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_insert_kernel (ins_k),
        .i_insert_matrix (ins_m),
        .i_data_in       (din),
        .i_ready         (ready),
        .o_done          (done2),
        .o_data_out      (dout2),
        .o_busy          (busy2),
        .o_kernel_loaded (kl2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Monitor: handshakes complete on the following rising edge when done && ready here.
    always @(negedge clk) begin
        if (!rst) begin
            if (done0 && !ready && q0.size() > 0) begin
                check("hold_data_out", longint'(dout0), q0[0]);
            end
            if (done0 && ready) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %0d, expected no output", dout0);
                end else begin
                    check($sformatf("data_out[%0d]", n_hs), longint'(dout0), q0.pop_front());
                end
                n_hs++;
            end
            if (done2 && ready) begin
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_shift2: got %0d, expected no output", dout2);
                end else begin
                    check("data_out_shift2", longint'(dout2), q2.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_kernel();
        for (int n = 0; n < K*K; n++) begin
            ins_k = 1'b1;
            din   = 16'(km[n]);
            tick();
        end
        ins_k = 1'b0;
        din   = '0;
    endtask

    task automatic load_matrix();
        for (int n = 0; n < D*D; n++) begin
            ins_m = 1'b1;
            din   = 16'(mm[n]);
            tick();
        end
        ins_m = 1'b0;
        din   = '0;
    endtask

    // Reference convolution with zero padding, pushed in raster order.
    task automatic push_expected();
        longint acc;
        int     rr;
        int     cc;
        for (int r = 0; r < D; r++) begin
            for (int c = 0; c < D; c++) begin
                acc = 0;
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K; j++) begin
                        rr = r + i - P;
                        cc = c + j - P;
                        if (rr >= 0 && rr < D && cc >= 0 && cc < D) begin
                            acc += longint'(km[i*K+j]) * longint'(mm[rr*D+cc]);
                        end
                    end
                end
                q0.push_back(sat16(acc));
                q2.push_back(sat16(acc >>> 2));
            end
        end
    endtask

    // Cycles from the current edge until done rises; 0 if it never does.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (done0) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int ok;
        ok = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (!busy0 && !busy2 && q0.size() == 0 && q2.size() == 0) begin
                ok = 1;
                break;
            end
        end
        check({name, "_finished"}, ok, 1);
        check({name, "_done_low"}, done0, 0);
        check({name, "_busy_low"}, busy0, 0);
        check({name, "_q_empty"}, q0.size(), 0);
    endtask

    task automatic run_matrix(input string name);
        int lat;
        int base;
        tick();
        push_expected();
        base = n_hs;
        load_matrix();
        wait_done(lat);
        check({name, "_first_latency"}, lat, K*K + 1);
        wait_idle(name);
        check({name, "_handshakes"}, n_hs - base, D*D);
    endtask

    initial begin
        int lat;
        int base;
        int saw;
        int hs_before;
        int reached;

        rst   = 1'b1;
        ins_k = 1'b0;
        ins_m = 1'b0;
        ready = 1'b1;
        din   = '0;
        repeat (3) tick();
        check("reset_done", done0, 0);
        check("reset_busy", busy0, 0);
        check("reset_kernel_loaded", kl0, 0);
        check("reset_data_out", dout0, 0);
        check("reset_busy_shift2", busy2, 0);
        rst = 1'b0;
        tick();

        // Identity kernel, matrix[n] = n
        for (int n = 0; n < K*K; n++) km[n] = (n == 4) ? 1 : 0;
        for (int n = 0; n < D*D; n++) mm[n] = n;
        load_kernel();
        check("kernel_loaded_identity", kl0, 1);
        run_matrix("identity");

        // All-ones kernel and matrix: corners 4, edges 6, interior 9
        for (int n = 0; n < K*K; n++) km[n] = 1;
        for (int n = 0; n < D*D; n++) mm[n] = 1;
        tick();
        load_kernel();
        check("kernel_loaded_ones", kl0, 1);
        run_matrix("ones");

        // Kernel reuse with saturating matrices
        for (int n = 0; n < D*D; n++) mm[n] = 32767;
        run_matrix("pos_sat");
        for (int n = 0; n < D*D; n++) mm[n] = -32768;
        run_matrix("neg_sat");

        // Partial kernel load drops kernel_loaded; matrix then waits for a full kernel
        for (int n = 0; n < K*K; n++) km[n] = (n % 2 == 0) ? (n + 1) : -(n + 1);
        for (int n = 0; n < 4; n++) begin
            ins_k = 1'b1;
            din   = 16'(km[n]);
            tick();
        end
        ins_k = 1'b0;
        tick();
        check("partial_kernel_not_loaded", kl0, 0);
        for (int n = 0; n < D*D; n++) mm[n] = ((n * 37) % 201) - 100;
        push_expected();
        base = n_hs;
        load_matrix();
        saw = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done0 || busy0) saw = 1;
        end
        check("no_activity_without_kernel", saw, 0);
        load_kernel();
        wait_done(lat);
        check("latency_from_kernel", lat, K*K + 1);

        // Inserts while busy are ignored
        ins_m = 1'b1;
        ins_k = 1'b1;
        din   = 16'sh1234;
        repeat (4) tick();
        ins_m = 1'b0;
        ins_k = 1'b0;
        din   = '0;
        check("busy_during_inserts", busy0, 1);
        check("kernel_kept_during_inserts", kl0, 1);

        // Backpressure: hold ready low for 10 cycles with done high
        wait_done(lat);
        check("bp_done_seen", lat > 0, 1);
        ready     = 1'b0;
        hs_before = n_hs;
        repeat (10) tick();
        check("bp_done_held", done0, 1);
        check("bp_no_advance", n_hs, hs_before);
        ready = 1'b1;
        tick();
        check("bp_handshake_drops_done", done0, 0);
        wait_done(lat);
        check("bp_next_latency", lat, K*K + 1);
        wait_idle("waited_matrix");
        check("waited_matrix_handshakes", n_hs - base, D*D);

        // Reset while computing output 37, then a fresh full run
        for (int n = 0; n < K*K; n++) km[n] = ((n * 3) % 7) - 3;
        tick();
        load_kernel();
        for (int n = 0; n < D*D; n++) mm[n] = ((n % D) * 300) - ((n / D) * 250);
        tick();
        push_expected();
        base = n_hs;
        load_matrix();
        reached = 0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (n_hs - base >= 37) begin
                reached = 1;
                break;
            end
        end
        check("reach_output_37", reached, 1);
        tick();
        check("pre_reset_busy", busy0, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_done", done0, 0);
        check("rst_mid_busy", busy0, 0);
        check("rst_mid_kernel_loaded", kl0, 0);
        check("rst_mid_data_out", dout0, 0);
        q0.delete();
        q2.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        load_kernel();
        check("kernel_loaded_after_reset", kl0, 1);
        run_matrix("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv2d_stream_engine.md
Name: conv2d_stream_engine

Overview:
Parametrised successor to the fixed 16x16 / 3x3 TPU convolution datapath. Kernel and matrix words arrive serially on one input bus under insert_kernel / insert_matrix strobes. The block computes a zero-padded "same"-size 2D convolution with one MAC per cycle. Results stream out in raster order under a valid/ready handshake, with output shift, saturation and kernel reuse across matrices.

Parameters:
MATRIX_DIM, 16, rows = cols of input/output matrix (>=2)
KERNEL_DIM, 3, kernel rows = cols; odd, 1..MATRIX_DIM
DATA_W, 16, signed two's-complement width of data_in/data_out
ACC_W, 40, signed accumulator width (>= 2*DATA_W + clog2(KERNEL_DIM^2))
OUT_SHIFT, 0, arithmetic right shift applied to accumulator before saturation

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
insert_kernel  in  1  capture data_in as next kernel word
insert_matrix  in  1  capture data_in as next matrix word
data_in  in  DATA_W  serial kernel/matrix word, raster order, row 0 first
ready  in  1  consumer accepts data_out this cycle
done  out  1  data_out valid
data_out  out  DATA_W  result word, raster order
busy  out  1  high in COMPUTE/OUTPUT; inserts ignored
kernel_loaded  out  1  full kernel held; sticky until reset or new kernel load begins

Behaviour:
- Reset (async, rst=1): state IDLE; done=0, busy=0, kernel_loaded=0, data_out=0; all counters 0; kernel/matrix storage contents don't-care.
- States: IDLE, LOAD_K, LOAD_M, COMPUTE, OUTPUT.
- IDLE: insert_kernel=1 -> LOAD_K, word captured at index 0 same edge, kernel_loaded cleared. Else insert_matrix=1 -> LOAD_M, index 0 captured. Both high: kernel wins.
- LOAD_K: one word per cycle while insert_kernel=1. After word KERNEL_DIM^2-1: kernel_loaded=1, extra strobe cycles ignored. insert_kernel low -> IDLE. Deassert before full: kernel_loaded stays 0, partial load discarded.
- LOAD_M: one word per cycle while insert_matrix=1. After word MATRIX_DIM^2-1: if kernel_loaded -> COMPUTE next edge, else extra strobe cycles ignored and -> IDLE on deassert; matrix retained, compute starts when a later kernel load completes. Early deassert -> IDLE, partial matrix discarded.
- COMPUTE (busy=1) per output (r,c): K^2 cycles, one MAC each over (i,j) raster. Term = k[i][j]*m[r+i-P][c+j-P], P=(KERNEL_DIM-1)/2. Out-of-range coordinate -> 0 (zero padding). Sign-extended product accumulated in ACC_W. Then 1 finalise cycle: acc>>>OUT_SHIFT saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1], registered to data_out -> OUTPUT.
- OUTPUT: done=1, data_out held stable until done&&ready. On handshake: last (r,c)=(D-1,D-1) -> IDLE (done=0, busy=0), else COMPUTE for next raster position, done=0.
- Latency: first done exactly KERNEL_DIM^2+1 cycles after edge capturing last matrix word (or last kernel word if matrix waited). Each later done KERNEL_DIM^2+1 cycles after preceding handshake. ready=1 constantly -> one word per K^2+2 cycles.
- insert_kernel/insert_matrix while busy: ignored, no state change.
- Kernel persists after a run: new matrix load alone triggers recompute.
- Reset mid-operation: immediate abort, all outputs to reset values, kernel_loaded=0.
- No combinational path from inputs to done/data_out.

Decomposition:
- Package tpu_pkg: data_t (logic signed [DATA_W-1:0]), acc_t, state enum conv_state_e, sat_shift function (shift + saturate).
- Sub-module conv_mac_unit: multiply-accumulate with clear, enable, padding-zero input, and finalise (shift+saturate) output. Control FSM, address counters and storage stay in conv2d_stream_engine.

Test Plan:
- Identity kernel (centre 1, rest 0), matrix[n]=n (16x16), ready=1 -> data_out[n]=n for all 256; first done at cycle 10 after last matrix word.
- All-ones kernel, all-ones matrix -> corners 4, non-corner edges 6, interior 9; exactly 256 handshakes, then done=0, busy=0.
- DATA_W=16, all-ones kernel, matrix all 0x7FFF -> every output 0x7FFF (saturated); matrix all 0x8000 -> every output 0x8000; OUT_SHIFT=2 with all-ones inputs -> interior 2, corners 1.
- Backpressure: ready low 10 cycles while done=1 -> data_out unchanged, no index advance; ready high -> next word follows after K^2+1 cycles.
- Kernel reuse and ordering: matrix loaded before kernel -> no done until kernel completes. Second matrix without new kernel -> correct results. insert_matrix pulses during busy -> ignored.
- rst pulse during COMPUTE at output 37 -> done=0, busy=0, kernel_loaded=0 same cycle. Fresh kernel+matrix load -> full correct 256-word result.
